// File: rtl/sram_pkg.sv
// Shared types and constants for the dual asynchronous SRAM controller.
package sram_pkg;

  localparam int unsigned BANK_BIT = 16;
  localparam int unsigned SRAM_AW  = 18;
  localparam int unsigned SRAM_DW  = 16;

  // {en_n, oe_n, we_n} for a chip that is not being accessed
  localparam logic [2:0] STROBE_IDLE = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StWSetup,
    StWPulse,
    StWHold,
    StRSetup,
    StRWait,
    StDone
  } state_e;

endpackage

// File: rtl/sram_bank_if.sv
// Pin driver for one asynchronous SRAM chip: registers strobes, address and bus enable
// so the chip pins never see combinational glitches from the request side.
module sram_bank_if import sram_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel,
  input  logic               drive,
  input  logic               oe_n,
  input  logic               we_n,
  input  logic [BANK_BIT-1:0] address,
  input  logic [SRAM_DW-1:0] wdata,
  output logic               ram_en,
  output logic               ram_oe,
  output logic               ram_we,
  output logic [SRAM_AW-1:0] ram_addr,
  inout  wire  [SRAM_DW-1:0] ram_data,
  output logic [SRAM_DW-1:0] rdata
);

  logic [2:0]         strobe_q;
  logic               drive_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [SRAM_DW-1:0] wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobe_q <= STROBE_IDLE;
      drive_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      strobe_q <= sel ? {1'b0, oe_n, we_n} : STROBE_IDLE;
      drive_q  <= sel & drive;
      addr_q   <= sel ? {{(SRAM_AW - BANK_BIT){1'b0}}, address} : '0;
      wdata_q  <= wdata;
    end
  end

  assign ram_en   = strobe_q[2];
  assign ram_oe   = strobe_q[1];
  assign ram_we   = strobe_q[0];
  assign ram_addr = addr_q;
  assign ram_data = drive_q ? wdata_q : {SRAM_DW{1'bz}};
  assign rdata    = ram_data;

endmodule

// File: rtl/sram_dual_ctrl.sv
// Single-word read/write controller for two asynchronous 16-bit SRAMs; addr[16] picks the chip.
module sram_dual_ctrl import sram_pkg::*; #(
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               re,
  input  logic               we,
  input  logic [BANK_BIT:0]  addr,
  input  logic [SRAM_DW-1:0] data_in,
  output logic [SRAM_DW-1:0] data_out,
  output logic               done,
  output logic               busy,
  output logic [SRAM_AW-1:0] ram_addr1,
  output logic [SRAM_AW-1:0] ram_addr2,
  inout  wire  [SRAM_DW-1:0] ram_data1,
  inout  wire  [SRAM_DW-1:0] ram_data2,
  output logic               ram1EN,
  output logic               ram2EN,
  output logic               ram1OE,
  output logic               ram2OE,
  output logic               ram1WE,
  output logic               ram2WE
);

  localparam int unsigned CW = $clog2(WAIT_CYC + 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BANK_BIT-1:0] addr_q, addr_d;
  logic                bank_q, bank_d;
  logic [SRAM_DW-1:0]  wdata_q, wdata_d;
  logic [SRAM_DW-1:0]  data_out_q;
  logic                rd_sample;
  logic                act, drive, oe_n, we_n;
  logic [SRAM_DW-1:0]  rdata1, rdata2;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    bank_d    = bank_q;
    wdata_d   = wdata_q;
    rd_sample = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en && (we || re)) begin
          state_d = we ? StWSetup : StRSetup;
          addr_d  = addr[BANK_BIT-1:0];
          bank_d  = addr[BANK_BIT];
          wdata_d = we ? data_in : wdata_q;
        end
      end
      StWSetup: begin
        state_d = StWPulse;
        cnt_d   = CW'(WAIT_CYC);
      end
      StWPulse: begin
        if (cnt_q == CW'(1)) state_d = StWHold;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      StWHold:  state_d = StDone;
      StRSetup: begin
        state_d = StRWait;
        cnt_d   = CW'(WAIT_CYC);
      end
      StRWait: begin
        if (cnt_q == CW'(1)) begin
          state_d   = StDone;
          rd_sample = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Pin controls are decoded from the next state so the registered pins line up with state_q.
  always_comb begin
    act   = 1'b0;
    drive = 1'b0;
    oe_n  = 1'b1;
    we_n  = 1'b1;
    case (state_d)
      StWSetup, StWHold: begin
        act   = 1'b1;
        drive = 1'b1;
      end
      StWPulse: begin
        act   = 1'b1;
        drive = 1'b1;
        we_n  = 1'b0;
      end
      StRSetup, StRWait: begin
        act  = 1'b1;
        oe_n = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      bank_q     <= 1'b0;
      wdata_q    <= '0;
      data_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      wdata_q <= wdata_d;
      if (rd_sample) data_out_q <= bank_q ? rdata2 : rdata1;
    end
  end

  assign data_out = data_out_q;
  assign done     = (state_q == StDone);
  assign busy     = (state_q != StIdle);

  sram_bank_if u_bank1 (
    .clk      (clk),
    .rst      (rst),
    .sel      (act & ~bank_d),
    .drive    (drive),
    .oe_n     (oe_n),
    .we_n     (we_n),
    .address  (addr_d),
    .wdata    (wdata_d),
    .ram_en   (ram1EN),
    .ram_oe   (ram1OE),
    .ram_we   (ram1WE),
    .ram_addr (ram_addr1),
    .ram_data (ram_data1),
    .rdata    (rdata1)
  );

  sram_bank_if u_bank2 (
    .clk      (clk),
    .rst      (rst),
    .sel      (act & bank_d),
    .drive    (drive),
    .oe_n     (oe_n),
    .we_n     (we_n),
    .address  (addr_d),
    .wdata    (wdata_d),
    .ram_en   (ram2EN),
    .ram_oe   (ram2OE),
    .ram_we   (ram2WE),
    .ram_addr (ram_addr2),
    .ram_data (ram_data2),
    .rdata    (rdata2)
  );

endmodule

// File: tb/tb_sram_dual_ctrl.sv
// Scoreboard bench: dut_a (WAIT_CYC=1, zero-latency SRAM models), dut_b (WAIT_CYC=3, 2-cycle SRAM).
module tb_sram_dual_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        en_a, re_a, we_a, en_b, re_b, we_b;
  logic [16:0] addr_a, addr_b;
  logic [15:0] din_a, din_b, dout_a, dout_b;
  logic        done_a, busy_a, done_b, busy_b;
  logic [17:0] ra1_a, ra2_a, ra1_b, ra2_b;
  wire  [15:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        e1_a, e2_a, o1_a, o2_a, w1_a, w2_a;
  logic        e1_b, e2_b, o1_b, o2_b, w1_b, w2_b;

  sram_dual_ctrl #(.WAIT_CYC(1)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .re(re_a), .we(we_a), .addr(addr_a), .data_in(din_a),
    .data_out(dout_a), .done(done_a), .busy(busy_a), .ram_addr1(ra1_a), .ram_addr2(ra2_a),
    .ram_data1(rd1_a), .ram_data2(rd2_a), .ram1EN(e1_a), .ram2EN(e2_a), .ram1OE(o1_a),
    .ram2OE(o2_a), .ram1WE(w1_a), .ram2WE(w2_a)
  );

  sram_dual_ctrl #(.WAIT_CYC(3)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .re(re_b), .we(we_b), .addr(addr_b), .data_in(din_b),
    .data_out(dout_b), .done(done_b), .busy(busy_b), .ram_addr1(ra1_b), .ram_addr2(ra2_b),
    .ram_data1(rd1_b), .ram_data2(rd2_b), .ram1EN(e1_b), .ram2EN(e2_b), .ram1OE(o1_b),
    .ram2OE(o2_b), .ram1WE(w1_b), .ram2WE(w2_b)
  );

  // SRAM models: drive while selected with OE low and WE high, capture while EN and WE low.
  logic [15:0] mem1_a [256] = '{default: 16'h0000};
  logic [15:0] mem2_a [256] = '{default: 16'h0000};
  logic [15:0] mem1_b [256] = '{7: 16'h4C4B, default: 16'h0000};
  int          acc_b = 0;

  assign rd1_a = (!e1_a && !o1_a && w1_a) ? mem1_a[ra1_a[7:0]] : 16'hzzzz;
  assign rd2_a = (!e2_a && !o2_a && w2_a) ? mem2_a[ra2_a[7:0]] : 16'hzzzz;
  assign rd1_b = (!e1_b && !o1_b && w1_b) ? ((acc_b >= 2) ? mem1_b[ra1_b[7:0]] : 16'hDEAD)
                                          : 16'hzzzz;

  always @(posedge clk) begin
    if (!e1_a && !w1_a) mem1_a[ra1_a[7:0]] <= rd1_a;
    if (!e2_a && !w2_a) mem2_a[ra2_a[7:0]] <= rd2_a;
    acc_b <= (!e1_b && !o1_b) ? acc_b + 1 : 0;
  end

  typedef struct {
    bit          rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t it;
    if (done_a) begin
      chk("done_expected_a", 32'(qa.size() > 0), 1);
      if (qa.size() > 0) begin
        it = qa.pop_front();
        chk("done_cycle_a", cyc, it.cyc);
        if (it.rd) chk("rdata_a", dout_a, it.data);
      end
    end
    if (done_b) begin
      chk("done_expected_b", 32'(qb.size() > 0), 1);
      if (qb.size() > 0) begin
        it = qb.pop_front();
        chk("done_cycle_b", cyc, it.cyc);
        if (it.rd) chk("rdata_b", dout_b, it.data);
      end
    end
  end

  // For reads, d is the word the model should return.
  task automatic issue(input bit b, input bit r, input bit w, input logic [16:0] a,
                       input logic [15:0] d, input bit keep, input bit exp_done, output int t);
    exp_t it;
    @(negedge clk);
    for (int k = 0; k < 20 && (b ? busy_b : busy_a); k++) @(negedge clk);
    if (b ? busy_b : busy_a) chk("idle_wait", b ? busy_b : busy_a, 0);
    if (!b) begin
      en_a = 1'b1; re_a = r; we_a = w; addr_a = a; din_a = d;
    end else begin
      en_b = 1'b1; re_b = r; we_b = w; addr_b = a; din_b = d;
    end
    @(posedge clk);
    #1;
    t = cyc;
    if ((r || w) && exp_done) begin
      it.rd   = !w;
      it.data = d;
      it.cyc  = t + (w ? 2 : 1) + (b ? 3 : 1);
      if (!b) qa.push_back(it);
      else    qb.push_back(it);
    end
    if (!keep) begin
      en_a = 1'b0;
      en_b = 1'b0;
    end
  endtask

  int          en_lo1, en_lo2, oe_lo1, oe_lo2, we_lo1, we_lo2, conflict, wbad, abad;
  logic [15:0] exp_wd;
  logic [16:0] exp_addr;

  task automatic clr_stats();
    en_lo1 = 0; en_lo2 = 0; oe_lo1 = 0; oe_lo2 = 0; we_lo1 = 0; we_lo2 = 0;
    conflict = 0; wbad = 0; abad = 0;
  endtask

  task automatic observe(input int n);
    repeat (n) begin
      @(negedge clk);
      if (!e1_a) en_lo1++;
      if (!e2_a) en_lo2++;
      if (!o1_a) oe_lo1++;
      if (!o2_a) oe_lo2++;
      if (!w1_a) we_lo1++;
      if (!w2_a) we_lo2++;
      if ((dut_a.u_bank1.drive_q && !o1_a) || (dut_a.u_bank2.drive_q && !o2_a)) conflict++;
      if (dut_a.u_bank1.drive_q && rd1_a !== exp_wd) wbad++;
      if (dut_a.u_bank2.drive_q && rd2_a !== exp_wd) wbad++;
      if (!e1_a && ra1_a !== {2'b00, exp_addr[15:0]}) abad++;
      if (!e2_a && ra2_a !== {2'b00, exp_addr[15:0]}) abad++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected end of test");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b0;
    en_a = 0; re_a = 0; we_a = 0; addr_a = '0; din_a = '0;
    en_b = 0; re_b = 0; we_b = 0; addr_b = '0; din_b = '0;
    exp_wd = '0; exp_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_strobes_a", {e1_a, e2_a, o1_a, o2_a, w1_a, w2_a}, 6'h3f);
    chk("rst_strobes_b", {e1_b, e2_b, o1_b, o2_b, w1_b, w2_b}, 6'h3f);
    chk("rst_flags_a", {done_a, busy_a, dout_a}, 18'h0);
    chk("rst_addr_a", {ra1_a, ra2_a}, 36'h0);
    chk("rst_drive_a", {dut_a.u_bank1.drive_q, dut_a.u_bank2.drive_q}, 2'b00);
    @(negedge clk);
    rst = 1'b1;

    // Write RAM1
    clr_stats(); exp_wd = 16'hA5A5; exp_addr = 17'h00005;
    issue(0, 0, 1, 17'h00005, 16'hA5A5, 0, 1, t);
    observe(4);
    chk("w1_en_low_cycles", en_lo1, 3);
    chk("w1_we_low_cycles", we_lo1, 1);
    chk("w1_oe_low_cycles", oe_lo1, 0);
    chk("w1_bus_data", wbad, 0);
    chk("w1_addr", abad, 0);
    chk("w1_ram2_idle", en_lo2 + oe_lo2 + we_lo2, 0);
    chk("busy_in_done", busy_a, 1);
    @(negedge clk);
    chk("busy_after_done", busy_a, 0);

    // Write then read RAM2
    clr_stats(); exp_wd = 16'h1234; exp_addr = 17'h10010;
    issue(0, 0, 1, 17'h10010, 16'h1234, 0, 1, t);
    observe(4);
    issue(0, 1, 0, 17'h10010, 16'h1234, 0, 1, t);
    observe(3);
    chk("r2_en_low_cycles", en_lo2, 5);
    chk("r2_we_low_cycles", we_lo2, 1);
    chk("r2_oe_low_cycles", oe_lo2, 2);
    chk("r2_ram1_idle", en_lo1 + oe_lo1 + we_lo1, 0);
    chk("r2_bus_conflict", conflict, 0);
    chk("r2_bus_data", wbad, 0);
    chk("r2_addr", abad, 0);

    // re and we both high: treated as a write
    clr_stats(); exp_wd = 16'h00FF; exp_addr = 17'h00001;
    issue(0, 1, 1, 17'h00001, 16'h00FF, 0, 1, t);
    observe(4);
    chk("rw_we_low_cycles", we_lo1, 1);
    chk("rw_oe_low_cycles", oe_lo1, 0);
    chk("rw_bus_data", wbad, 0);
    issue(0, 1, 0, 17'h00001, 16'h00FF, 0, 1, t);
    issue(0, 1, 0, 17'h00005, 16'hA5A5, 0, 1, t);

    // en without re/we is ignored
    clr_stats();
    issue(0, 0, 0, 17'h00005, 16'h0000, 0, 1, t);
    observe(3);
    chk("ign_no_enable", en_lo1 + en_lo2, 0);
    chk("ign_not_busy", busy_a, 0);

    // Request held through a write while addr/data change; only the IDLE-edge value counts
    issue(0, 0, 1, 17'h00020, 16'h1111, 1, 1, t);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      addr_a = 17'h00030 + 17'(i);
      din_a  = 16'h2200 + 16'(i);
    end
    @(negedge clk);
    addr_a = 17'h00040;
    din_a  = 16'hBEEF;
    @(posedge clk);
    #1;
    qa.push_back('{rd: 1'b0, data: 16'hBEEF, cyc: t + 8});
    en_a = 1'b0;
    issue(0, 1, 0, 17'h00020, 16'h1111, 0, 1, t);
    issue(0, 1, 0, 17'h00040, 16'hBEEF, 0, 1, t);
    issue(0, 1, 0, 17'h00031, 16'h0000, 0, 1, t);

    // Reset during the WE pulse
    issue(0, 0, 1, 17'h00050, 16'h5555, 0, 0, t);
    @(posedge clk);
    #1;
    chk("abort_in_pulse", w1_a, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_we_high", w1_a, 1);
    chk("abort_en_high", e1_a, 1);
    chk("abort_bus_released", dut_a.u_bank1.drive_q, 0);
    chk("abort_data_out", dout_a, 0);
    chk("abort_busy", busy_a, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    issue(0, 1, 0, 17'h10010, 16'h1234, 0, 1, t);

    // Longer wait against a 2-cycle access memory
    issue(1, 1, 0, 17'h00007, 16'h4C4B, 0, 1, t);

    for (int k = 0; k < 50 && (qa.size() > 0 || qb.size() > 0); k++) @(negedge clk);
    chk("pending_a", qa.size(), 0);
    chk("pending_b", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
